// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for the iterative binary32 divider.
// The master drives the operands and consumes the quotient.
interface fp_div_iter_if;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_res;
  logic        o_valid;
  logic        i_ready;

  modport master (
    output i_a, i_b, i_valid, i_ready,
    input  o_ready, o_res, o_valid
  );

  modport slave (
    input  i_a, i_b, i_valid, i_ready,
    output o_ready, o_res, o_valid
  );
endinterface

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider, radix-2 restoring, one quotient bit per cycle.
// Define FP_DIV_ROUND_EN for round-to-nearest-even (default truncates).
module fp_div_iter (
  input  logic   i_clk,
  input  logic   i_rst_n,
  fp_div_iter_if.slave io
);
`ifdef FP_DIV_ROUND_EN
  localparam int QW = 27;
`else
  localparam int QW = 25;
`endif
  localparam logic [4:0] LAST = 5'(QW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_PACK  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state;
  logic [31:0]        a_r, b_r, res;
  logic               sign;
  logic [23:0]        ma, mb;
  logic signed [10:0] ea, eb;
  logic [25:0]        r;
  logic [QW-1:0]      q;
  logic [4:0]         cnt;

  logic [7:0]  xa, xb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        is_nan, is_inf, is_zero, any_sub, sgn;
  logic [23:0] ma0, mb0, na, nb;
  logic signed [10:0] ea0, eb0, nea, neb;

  assign xa = a_r[30:23];
  assign xb = b_r[30:23];
  assign fa = a_r[22:0];
  assign fb = b_r[22:0];
  assign sgn = a_r[31] ^ b_r[31];

  assign a_zero = (xa == 8'd0) && (fa == 23'd0);
  assign b_zero = (xb == 8'd0) && (fb == 23'd0);
  assign a_inf  = (xa == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (xb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (xa == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (xb == 8'hFF) && (fb != 23'd0);

  // Mutually exclusive so the decoder below can be unique.
  assign is_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign is_inf  = !is_nan & (a_inf | b_zero);
  assign is_zero = !is_nan & !is_inf & (a_zero | b_inf);
  assign any_sub = ((xa == 8'd0) && (fa != 23'd0))
                 | ((xb == 8'd0) && (fb != 23'd0));

  assign ma0 = {|xa, fa};
  assign mb0 = {|xb, fb};
  assign ea0 = (xa == 8'd0) ? 11'sd1 : $signed({3'd0, xa});
  assign eb0 = (xb == 8'd0) ? 11'sd1 : $signed({3'd0, xb});

  assign na  = ma[23] ? ma : ma << 1;
  assign nb  = mb[23] ? mb : mb << 1;
  assign nea = ma[23] ? ea : ea - 11'sd1;
  assign neb = mb[23] ? eb : eb - 11'sd1;

  logic        ge;
  logic [25:0] rd;
  assign ge = r >= {2'd0, mb};
  assign rd = ge ? r - {2'd0, mb} : r;

  logic signed [10:0] e_p;
  logic [10:0]        sh;
  logic [7:0]         e_m1;
  logic [31:0]        pk;

  assign e_p  = ea - eb + 11'sd127 - (q[QW-1] ? 11'sd0 : 11'sd1);
  assign sh   = 11'd1 - e_p;
  assign e_m1 = e_p[7:0] - 8'd1;

`ifdef FP_DIV_ROUND_EN
  logic [25:0] ext, exs, mask;
  logic [7:0]  ef;
  logic        st, lost, inc;

  always_comb begin
    ext  = q[26] ? q[26:1] : q[25:0];
    st   = (q[26] & q[0]) | (|r);
    mask = ~(26'h3FF_FFFF << sh);
    exs  = ext;
    lost = 1'b0;
    ef   = e_m1;
    if (e_p <= 11'sd0) begin
      ef = 8'd0;
      if (sh >= 11'd26) begin
        exs  = 26'd0;
        lost = |ext;
      end else begin
        exs  = ext >> sh;
        lost = |(ext & mask);
      end
    end
    // Carry out of the fraction walks into the exponent field.
    inc = exs[1] & (exs[0] | lost | st | exs[2]);
    if (e_p >= 11'sd255)
      pk = {sign, 8'hFF, 23'd0};
    else
      pk = {sign, ef, 23'd0} + {8'd0, exs[25:2]} + {31'd0, inc};
  end
`else
  logic [23:0] m24, sm;

  always_comb begin
    m24 = q[24] ? q[24:1] : q[23:0];
    sm  = (sh < 11'd24) ? m24 >> sh : 24'd0;
    if (e_p >= 11'sd255)
      pk = {sign, 8'hFF, 23'd0};
    else if (e_p > 11'sd0)
      pk = {sign, e_m1, 23'd0} + {8'd0, m24};
    else
      pk = {sign, 31'd0} + {8'd0, sm};
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      res   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sign  <= 1'b0;
      ma    <= '0;
      mb    <= '0;
      ea    <= '0;
      eb    <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.i_valid) begin
            a_r   <= io.i_a;
            b_r   <= io.i_b;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          sign <= sgn;
          ma   <= ma0;
          mb   <= mb0;
          ea   <= ea0;
          eb   <= eb0;
          r    <= {2'd0, ma0};
          q    <= '0;
          cnt  <= '0;
          unique case (1'b1)
            is_nan: begin
              res   <= 32'hFFFF_FFFF;
              state <= S_DONE;
            end
            is_inf: begin
              res   <= {sgn, 8'hFF, 23'd0};
              state <= S_DONE;
            end
            is_zero: begin
              res   <= {sgn, 31'd0};
              state <= S_DONE;
            end
            default: state <= any_sub ? S_NORM : S_DIV;
          endcase
        end
        S_NORM: begin
          ma <= na;
          mb <= nb;
          ea <= nea;
          eb <= neb;
          r  <= {2'd0, na};
          if (na[23] && nb[23])
            state <= S_DIV;
        end
        S_DIV: begin
          r   <= rd << 1;
          q   <= {q[QW-2:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == LAST)
            state <= S_PACK;
        end
        S_PACK: begin
          res   <= pk;
          state <= S_DONE;
        end
        S_DONE: begin
          if (io.i_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.o_ready = (state == S_IDLE);
  assign io.o_valid = (state == S_DONE);
  assign io.o_res   = res;
endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: exact-quotient reference model, per-cycle monitor,
// directed literals and randomized operands.
module tb_fp_div_iter;
`ifdef FP_DIV_ROUND_EN
  localparam int BASE = 29;
  localparam logic [31:0] R13 = 32'h3EAA_AAAB;
`else
  localparam int BASE = 27;
  localparam logic [31:0] R13 = 32'h3EAA_AAAA;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  fp_div_iter_if io ();

  fp_div_iter dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io     (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic bit f_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'd0;
  endfunction
  function automatic bit f_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 23'd0;
  endfunction
  function automatic bit f_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  function automatic bit special(input logic [31:0] a, input logic [31:0] b);
    return f_nan(a) || f_nan(b) || f_inf(a) || f_inf(b)
        || f_zero(a) || f_zero(b);
  endfunction

  function automatic int lz(input logic [31:0] x);
    int n;
    logic [23:0] m;
    n = 0;
    m = {x[30:23] != 8'd0, x[22:0]};
    while (!m[23] && n < 24) begin
      m = m << 1;
      n++;
    end
    return n;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    int la, lb;
    if (special(a, b)) return 1;
    la = lz(a);
    lb = lz(b);
    return BASE + ((la > lb) ? la : lb);
  endfunction

  // Value of an operand is m*2^(e-150); the quotient is found exactly
  // with wide integer division, then placed on the binary32 grid.
  function automatic logic [31:0] model_div(input logic [31:0] a,
                                            input logic [31:0] b);
    logic s;
    logic [63:0] ma, mb, num, q, rem, mant;
    int ea, eb, k, p, qn, sh, ex;
    s = a[31] ^ b[31];
    if (f_nan(a) || f_nan(b) || (f_zero(a) && f_zero(b))
        || (f_inf(a) && f_inf(b)))
      return 32'hFFFF_FFFF;
    if (f_inf(a) || f_zero(b)) return {s, 8'hFF, 23'd0};
    if (f_zero(a) || f_inf(b)) return {s, 31'd0};
    ma = {40'd0, a[30:23] != 8'd0, a[22:0]};
    mb = {40'd0, b[30:23] != 8'd0, b[22:0]};
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    while (!ma[23]) begin ma = ma << 1; ea--; end
    while (!mb[23]) begin mb = mb << 1; eb--; end
    num = ma << 40;
    q   = num / mb;
    rem = num % mb;
    p   = q[40] ? 40 : 39;
    k   = ea - eb - 40;
    qn  = (p + k - 23 > -149) ? p + k - 23 : -149;
    sh  = qn - k;
    mant = (sh >= 64) ? 64'd0 : q >> sh;
`ifdef FP_DIV_ROUND_EN
    begin
      logic g, st;
      if (sh >= 64) begin
        g  = 1'b0;
        st = (q != 64'd0) || (rem != 64'd0);
      end else begin
        g  = q[sh-1];
        st = ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0)
          || (rem != 64'd0);
      end
      if (g && (st || mant[0])) mant = mant + 64'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        qn++;
      end
    end
`endif
    if (!mant[23]) return {s, 8'd0, mant[22:0]};
    ex = qn + 150;
    if (ex >= 255) return {s, 8'hFF, 23'd0};
    return {s, ex[7:0], mant[22:0]};
  endfunction

  // Per-cycle monitor: checks outputs, then predicts the next edge.
  bit busy = 1'b0;
  bit zres = 1'b1;
  int e = 0;
  int lat = 0;
  logic [31:0] exp_res = 32'd0;

  always @(negedge clk) begin
    if (busy) begin
      check("mon_ready_busy", 32'(io.o_ready), 32'd0);
      check("mon_valid", 32'(io.o_valid), 32'(e >= lat));
      if (e >= lat) check("mon_result", io.o_res, exp_res);
    end else begin
      check("mon_ready_idle", 32'(io.o_ready), 32'd1);
      check("mon_valid_idle", 32'(io.o_valid), 32'd0);
      if (zres) check("mon_res_reset", io.o_res, 32'd0);
    end
    if (!rst_n) begin
      busy = 1'b0;
      zres = 1'b1;
    end else if (!busy) begin
      if (io.i_valid) begin
        busy    = 1'b1;
        zres    = 1'b0;
        e       = 0;
        lat     = model_lat(io.i_a, io.i_b);
        exp_res = model_div(io.i_a, io.i_b);
      end
    end else if (e >= lat && io.i_ready) begin
      busy = 1'b0;
    end else begin
      e++;
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit lit,
                        input logic [31:0] lres, input int llat);
    int w;
    w = 0;
    while (!io.o_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!io.o_ready) timeout("ready_wait");
    io.i_a     = a;
    io.i_b     = b;
    io.i_valid = 1'b1;
    io.i_ready = (hold == 0);
    @(posedge clk); #1;
    io.i_valid = 1'b0;
    w = 0;
    while (!io.o_valid && w < 120) begin
      @(posedge clk); #1;
      w++;
    end
    if (lit) begin
      check("lit_latency", 32'(w), 32'(llat));
      check("lit_result", io.o_res, lres);
    end else if (!io.o_valid) begin
      timeout("valid_wait");
    end
    for (int h = 0; h < hold; h++) begin
      io.i_valid = 1'b1;
      io.i_a     = $urandom;
      io.i_b     = $urandom;
      @(posedge clk); #1;
      if (lit) begin
        check("hold_valid", 32'(io.o_valid), 32'd1);
        check("hold_ready", 32'(io.o_ready), 32'd0);
        check("hold_result", io.o_res, lres);
      end
    end
    io.i_valid = 1'b0;
    io.i_ready = 1'b1;
    @(posedge clk); #1;
    if (lit) begin
      check("drain_valid", 32'(io.o_valid), 32'd0);
      check("drain_ready", 32'(io.o_ready), 32'd1);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    int kind;
    x    = $urandom;
    kind = $urandom_range(0, 9);
    case (kind)
      0: x[30:0] = 31'd0;
      1: x[30:0] = {8'hFF, 23'd0};
      2: x[30:23] = 8'hFF;
      3: x[30:23] = 8'd0;
      4: begin
        x[30:23] = 8'd0;
        x[22:0]  = 23'($urandom_range(1, 255));
      end
      5: x[30:23] = ($urandom_range(0, 1) != 0) ? 8'd254 : 8'd1;
      default: ;
    endcase
    return x;
  endfunction

  logic [31:0] da [12] = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000,
                           32'h0000_0000, 32'h7F80_0000, 32'hBF80_0000,
                           32'h0000_0001, 32'h7F00_0000, 32'h0080_0000,
                           32'h0080_0000, 32'hC0C0_0000, 32'h7FC0_0001};
  logic [31:0] db [12] = '{32'h4000_0000, 32'h4040_0000, 32'h0000_0000,
                           32'h0000_0000, 32'hFF80_0000, 32'h7F80_0000,
                           32'h3F00_0000, 32'h3F00_0000, 32'h4B00_0000,
                           32'h4B80_0000, 32'h4000_0000, 32'h3F80_0000};
  logic [31:0] dr [12] = '{32'h4040_0000, R13, 32'h7F80_0000,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                           32'h0000_0002, 32'h7F80_0000, 32'h0000_0001,
                           32'h0000_0000, 32'hC040_0000, 32'hFFFF_FFFF};
  int dl [12] = '{BASE, BASE, 1, 1, 1, 1, BASE + 23, BASE, BASE, BASE,
                  BASE, 1};

  initial begin
    io.i_a     = 32'h40C0_0000;
    io.i_b     = 32'h4000_0000;
    io.i_valid = 1'b1;
    io.i_ready = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    io.i_valid = 1'b0;
    rst_n      = 1'b1;
    check("reset_ready", 32'(io.o_ready), 32'd1);
    check("reset_valid", 32'(io.o_valid), 32'd0);
    check("reset_res", io.o_res, 32'd0);

    for (int i = 0; i < 12; i++)
      run_op(da[i], db[i], 0, 1'b1, dr[i], dl[i]);

    run_op(32'h40C0_0000, 32'h4000_0000, 10, 1'b1, 32'h4040_0000, BASE);

    io.i_a     = 32'h40C0_0000;
    io.i_b     = 32'h4000_0000;
    io.i_valid = 1'b1;
    @(posedge clk); #1;
    io.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_valid", 32'(io.o_valid), 32'd0);
    check("abort_res", io.o_res, 32'd0);
    check("abort_ready", 32'(io.o_ready), 32'd1);
    run_op(32'h40C0_0000, 32'h4000_0000, 0, 1'b1, 32'h4040_0000, BASE);

    for (int i = 0; i < 300; i++)
      run_op(rnd_op(), rnd_op(), $urandom_range(0, 2), 1'b0, 32'd0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
